// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths and complex sample types for the FFT pipeline
package fft_pkg;

  localparam int FFT_DATA_W = 9;
  localparam int FFT_HALF   = 16;

  // Complex sample as it enters a butterfly stage.
  typedef struct packed {
    logic signed [FFT_DATA_W-1:0] re;
    logic signed [FFT_DATA_W-1:0] im;
  } cplx_in_t;

  // Complex sample as held in the feedback line: one bit of growth.
  typedef struct packed {
    logic signed [FFT_DATA_W:0] re;
    logic signed [FFT_DATA_W:0] im;
  } cplx_sr_t;

endpackage

// File: rtl/bfly_delay_line.sv
// rtl/bfly_delay_line.sv - enabled shift register used as the SDF feedback line
module bfly_delay_line #(
  parameter int W     = 20,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sr [DEPTH];

  // Shift one entry per enabled cycle; entry DEPTH-1 is the oldest.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/fft_sdf_bfly_stage.sv
// rtl/fft_sdf_bfly_stage.sv - radix-2 SDF butterfly stage with phase checker
module fft_sdf_bfly_stage
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int DEPTH  = FFT_HALF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] din_re,
  input  logic signed [DATA_W-1:0] din_im,
  input  logic                     din_valid,
  input  logic                     mux_sel,
  output logic signed [DATA_W:0]   dout_re,
  output logic signed [DATA_W:0]   dout_im,
  output logic                     dout_valid,
  output logic                     err
);

  localparam int SW = DATA_W + 1;
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2*SW-1:0]        line_in;
  logic [2*SW-1:0]        line_out;
  logic signed [SW-1:0]   sr_re;
  logic signed [SW-1:0]   sr_im;
  logic signed [SW-1:0]   dx_re;
  logic signed [SW-1:0]   dx_im;
  logic signed [SW:0]     sum_re;
  logic signed [SW:0]     sum_im;
  logic signed [SW:0]     dif_re;
  logic signed [SW:0]     dif_im;
  logic                   primed;
  logic                   last_sel;
  logic [CW-1:0]          vcnt;

  assign {sr_re, sr_im} = line_out;
  assign dx_re = {din_re[DATA_W-1], din_re};
  assign dx_im = {din_im[DATA_W-1], din_im};

  // One extra guard bit; in a well-formed frame sr_out is a sign-extended
  // input, so the guard bit is always a copy of bit SW-1 and is dropped.
  assign sum_re = {sr_re[SW-1], sr_re} + {dx_re[SW-1], dx_re};
  assign sum_im = {sr_im[SW-1], sr_im} + {dx_im[SW-1], dx_im};
  assign dif_re = {sr_re[SW-1], sr_re} - {dx_re[SW-1], dx_re};
  assign dif_im = {sr_im[SW-1], sr_im} - {dx_im[SW-1], dx_im};

  assign line_in = mux_sel ? {dif_re[SW-1:0], dif_im[SW-1:0]} : {dx_re, dx_im};

  bfly_delay_line #(
    .W     (2*SW),
    .DEPTH (DEPTH)
  ) u_line (
    .clk  (clk),
    .rst  (rst),
    .en   (din_valid),
    .din  (line_in),
    .dout (line_out)
  );

  // Output register: butterfly sum in compute phase, oldest line entry in fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_re    <= '0;
      dout_im    <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= din_valid & (mux_sel | primed);
      if (din_valid) begin
        dout_re <= mux_sel ? sum_re[SW-1:0] : sr_re;
        dout_im <= mux_sel ? sum_im[SW-1:0] : sr_im;
      end
    end
  end

  // Priming, sample counter and sticky phase-error detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      primed   <= 1'b0;
      vcnt     <= '0;
      last_sel <= 1'b0;
      err      <= 1'b0;
    end else if (din_valid) begin
      if (mux_sel) primed <= 1'b1;
      vcnt     <= (vcnt == CW'(DEPTH - 1)) ? '0 : vcnt + CW'(1);
      last_sel <= mux_sel;
      if ((mux_sel != last_sel) && (vcnt != '0)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_sdf_bfly_stage.sv
// tb/tb_fft_sdf_bfly_stage.sv - scoreboard bench for the SDF butterfly stage
module tb_fft_sdf_bfly_stage;

  localparam int DW = 9;
  localparam int D  = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] din_re;
  logic signed [DW-1:0] din_im;
  logic                 din_valid;
  logic                 mux_sel;
  logic signed [DW:0]   dout_re;
  logic signed [DW:0]   dout_im;
  logic                 dout_valid;
  logic                 err;

  always #5 clk = ~clk;

  fft_sdf_bfly_stage #(.DATA_W(DW), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_re     (din_re),
    .din_im     (din_im),
    .din_valid  (din_valid),
    .mux_sel    (mux_sel),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .dout_valid (dout_valid),
    .err        (err)
  );

  typedef struct {
    int re;
    int im;
  } smp_t;

  smp_t exp_q[$];
  int   m_re[$];
  int   m_im[$];
  bit   m_primed;
  bit   use_model;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic signed [31:0] obs, input int expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_re.delete();
    m_im.delete();
    for (int i = 0; i < D; i++) begin
      m_re.push_back(0);
      m_im.push_back(0);
    end
    m_primed = 1'b0;
  endtask

  task automatic push_exp(input int re, input int im);
    smp_t e;
    e.re = re;
    e.im = im;
    exp_q.push_back(e);
  endtask

  // Drive one cycle, advance the golden line, then check the registered output.
  task automatic step(input bit v, input bit s, input int re, input int im);
    din_valid = v;
    mux_sel   = s;
    din_re    = DW'(re);
    din_im    = DW'(im);
    if (v) begin
      int ore;
      int oim;
      ore = m_re.pop_front();
      oim = m_im.pop_front();
      if (s) begin
        if (use_model) push_exp(ore + re, oim + im);
        m_re.push_back(ore - re);
        m_im.push_back(oim - im);
        m_primed = 1'b1;
      end else begin
        if (use_model && m_primed) push_exp(ore, oim);
        m_re.push_back(re);
        m_im.push_back(im);
      end
    end
    @(posedge clk);
    #1;
    if (!v) begin
      check("gap_valid", {31'd0, dout_valid}, 0);
    end else if (dout_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_out", {31'd0, dout_valid}, 0);
      end else begin
        smp_t e;
        e = exp_q.pop_front();
        check("dout_re", dout_re, e.re);
        check("dout_im", dout_im, e.im);
      end
    end
  endtask

  // Reset with a live-looking sample on the inputs; reset must win.
  task automatic do_reset();
    check("sb_empty", exp_q.size(), 0);
    rst       = 1'b1;
    din_valid = 1'b1;
    mux_sel   = 1'b1;
    din_re    = 9'sd77;
    din_im    = -9'sd33;
    @(posedge clk);
    #1;
    check("rst_dout_re", dout_re, 0);
    check("rst_dout_im", dout_im, 0);
    check("rst_dout_valid", {31'd0, dout_valid}, 0);
    check("rst_err", {31'd0, err}, 0);
    rst = 1'b0;
    exp_q.delete();
    model_reset();
  endtask

  // Ramp frame re=0..31, im=0, followed by a zero drain.
  task automatic frame_ramp();
    use_model = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i >= 16) push_exp(2 * i - 16, 0);
      step(1'b1, i >= 16, i, 0);
    end
    for (int i = 0; i < 16; i++) begin
      push_exp(-16, 0);
      step(1'b1, 1'b0, 0, 0);
    end
    check("ramp_sb_empty", exp_q.size(), 0);
    check("ramp_err", {31'd0, err}, 0);
  endtask

  // Constant halves a then b; sums a+b in compute, diffs a-b in drain.
  task automatic frame_const(input int a, input int b);
    use_model = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, a, a);
    for (int i = 0; i < 16; i++) begin
      push_exp(a + b, a + b);
      step(1'b1, 1'b1, b, b);
    end
    for (int i = 0; i < 16; i++) begin
      push_exp(a - b, a - b);
      step(1'b1, 1'b0, 0, 0);
    end
    check("const_sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst       = 1'b1;
    din_valid = 1'b0;
    mux_sel   = 1'b0;
    din_re    = '0;
    din_im    = '0;
    use_model = 1'b0;
    model_reset();

    // Cold start: ramp frame.
    do_reset();
    frame_ramp();

    // Impulse at slot 0.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      if (i >= 16) push_exp((i == 16) ? 100 : 0, (i == 16) ? -50 : 0);
      step(1'b1, i >= 16, (i == 0) ? 100 : 0, (i == 0) ? -50 : 0);
    end
    for (int i = 0; i < 16; i++) begin
      push_exp((i == 0) ? 100 : 0, (i == 0) ? -50 : 0);
      step(1'b1, 1'b0, 0, 0);
    end
    check("imp_sb_empty", exp_q.size(), 0);

    // Extremes: -512 / 0, then -1 / 511.
    do_reset();
    frame_const(-256, -256);
    do_reset();
    frame_const(255, -256);

    // Random gaps within two back-to-back frames, checked against the model.
    do_reset();
    use_model = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        int g;
        g = int'($urandom_range(1, 5));
        for (int k = 0; k < g; k++)
          step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 511)) - 256, 0);
      end
      if (i < 64)
        step(1'b1, (i % 32) >= 16, int'($urandom_range(0, 511)) - 256,
             int'($urandom_range(0, 511)) - 256);
      else
        step(1'b1, 1'b0, 0, 0);
    end
    check("rand_sb_empty", exp_q.size(), 0);
    check("rand_err", {31'd0, err}, 0);

    // Phase error: mux_sel rises after 10 valid samples.
    do_reset();
    use_model = 1'b1;
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100);
    check("err_before", {31'd0, err}, 0);
    step(1'b1, 1'b1, int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100);
    check("err_set", {31'd0, err}, 1);
    for (int i = 11; i < 96; i++) begin
      step(1'b1, (i % 32) >= 16, int'($urandom_range(0, 200)) - 100,
           int'($urandom_range(0, 200)) - 100);
      if ((i % 16) == 15) check("err_sticky", {31'd0, err}, 1);
    end

    // Mid-frame reset at sample 20, then a fresh frame must match a cold start.
    do_reset();
    use_model = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i >= 16) push_exp(2 * i - 16, 0);
      step(1'b1, i >= 16, i, 0);
    end
    do_reset();
    frame_ramp();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
